// File: rtl/inst_rom.sv
// Instruction store loaded byte-serially, fetched as a six-byte window.
// Latency: fetch is combinational (zero cycles); load writes land on the accepting edge.
// Backpressure: ld_ready is high only in LOAD; bytes offered in IDLE/FULL are dropped.
module inst_rom #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   rom_addr_i,
  output logic [47:0]   rom_data_o,
  output logic          rom_busy,
  input  logic          ld_start,
  input  logic          ld_valid,
  input  logic [7:0]    ld_data,
  output logic          ld_ready,
  input  logic          ld_end,
  output logic          ld_done,
  output logic [AW:0]   ld_count
);

  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_LOAD   = 2'd1;
  localparam logic [1:0]  S_FULL   = 2'd2;
  localparam logic [AW:0] LAST_CNT = (AW+1)'(DEPTH - 1);

  logic [1:0]  r_state;
  logic [AW:0] r_count;   // doubles as the write pointer
  logic        r_done;
  logic [7:0]  r_mem [DEPTH];

  logic        w_active;
  logic        w_wr_en;
  logic [47:0] w_data;

  assign w_active = (r_state == S_LOAD) || (r_state == S_FULL);
  // A restart discards any byte offered in the same cycle.
  assign w_wr_en  = (r_state == S_LOAD) && ld_valid && !ld_start;

  // Load control: restart beats end, end beats the transition into FULL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (ld_start) begin
        r_state <= S_LOAD;
        r_count <= '0;
      end else if (w_active) begin
        if (w_wr_en) begin
          r_count <= r_count + 1'b1;
        end
        if (ld_end) begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
        end else if (w_wr_en && (r_count == LAST_CNT)) begin
          r_state <= S_FULL;
        end
      end else if (r_state != S_IDLE) begin
        r_state <= S_IDLE;
      end
    end
  end

  // Byte store; never cleared, ld_count gates what is visible.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_count[AW-1:0]] <= ld_data;
    end
  end

  // Fetch window: bytes at or past ld_count read as zero, no wrap at 2^32.
  always_comb begin
    logic [32:0] w_addr;
    w_addr = '0;
    w_data = '0;
    if (!w_active) begin
      for (int i = 0; i < 6; i++) begin
        w_addr = {1'b0, rom_addr_i} + 33'(i);
        if (w_addr < 33'(r_count)) begin
          w_data[47-8*i -: 8] = r_mem[w_addr[AW-1:0]];
        end
      end
    end
  end

  assign rom_data_o = w_data;
  assign rom_busy   = w_active;
  assign ld_ready   = (r_state == S_LOAD);
  assign ld_done    = r_done;
  assign ld_count   = r_count;

endmodule

// File: tb/tb_inst_rom.sv
// Directed bench for inst_rom: load/fetch scenarios with a fetch scoreboard.
module tb_inst_rom;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   rom_addr_i;
  logic [47:0]   rom_data_o;
  logic          rom_busy;
  logic          ld_start;
  logic          ld_valid;
  logic [7:0]    ld_data;
  logic          ld_ready;
  logic          ld_end;
  logic          ld_done;
  logic [AW:0]   ld_count;

  int checks   = 0;
  int failures = 0;
  logic [47:0] exp_q [$];

  inst_rom #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .rom_addr_i(rom_addr_i), .rom_data_o(rom_data_o), .rom_busy(rom_busy),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_end(ld_end), .ld_done(ld_done), .ld_count(ld_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push the expected window, drive the address, then pop and compare.
  task automatic fetch(input string tag, input logic [31:0] addr, input logic [47:0] exp);
    logic [47:0] e;
    exp_q.push_back(exp);
    rom_addr_i = addr;
    #1;
    e = exp_q.pop_front();
    chk(tag, {16'h0, rom_data_o}, {16'h0, e});
  endtask

  task automatic send(input logic [7:0] b);
    ld_valid = 1'b1;
    ld_data  = b;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic finish_load(input string tag, input int exp_cnt);
    ld_end = 1'b1;
    tick();
    ld_end = 1'b0;
    chk({tag, "_done"}, 64'(ld_done), 64'd1);
    chk({tag, "_cnt"}, 64'(ld_count), 64'(exp_cnt));
    chk({tag, "_idle"}, 64'(rom_busy), 64'd0);
    tick();
    chk({tag, "_done_drop"}, 64'(ld_done), 64'd0);
  endtask

  function automatic logic [7:0] pat(input int i);
    logic [31:0] t;
    t = i;
    return t[7:0] ^ 8'h5A;
  endfunction

  initial begin
    logic [7:0]  prog [7];
    logic [47:0] w;
    prog = '{8'h30, 8'hF4, 8'h78, 8'h56, 8'h34, 8'h12, 8'h00};

    rst = 1'b1; rom_addr_i = '0; ld_start = 0; ld_valid = 0; ld_data = '0; ld_end = 0;
    #12;
    chk("rst_busy",  64'(rom_busy), 64'd0);
    chk("rst_ready", 64'(ld_ready), 64'd0);
    chk("rst_done",  64'(ld_done),  64'd0);
    chk("rst_count", 64'(ld_count), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    fetch("rst_fetch0", 32'h0, 48'h0);

    // IDLE ignores bytes and end pulses.
    ld_valid = 1'b1; ld_data = 8'hAB; ld_end = 1'b1;
    tick();
    ld_valid = 1'b0; ld_end = 1'b0;
    chk("idle_cnt",  64'(ld_count), 64'd0);
    chk("idle_busy", 64'(rom_busy), 64'd0);
    tick();
    chk("idle_done", 64'(ld_done),  64'd0);

    // Seven-byte program.
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    chk("p7_busy",  64'(rom_busy), 64'd1);
    chk("p7_ready", 64'(ld_ready), 64'd1);
    fetch("p7_busy_zero", 32'h0, 48'h0);
    for (int i = 0; i < 7; i++) send(prog[i]);
    chk("p7_cnt_live", 64'(ld_count), 64'd7);
    finish_load("p7", 7);
    fetch("p7_a0", 32'd0, 48'h30F478563412);
    fetch("p7_a2", 32'd2, 48'h785634120000);
    fetch("p7_a5", 32'd5, 48'h120000000000);
    fetch("p7_a6", 32'd6, 48'h000000000000);

    // Five bytes, last one presented together with ld_end.
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    send(8'hA1); send(8'hB2); send(8'hC3); send(8'hD4);
    ld_data = 8'hE5;
    ld_valid = 1'b1;
    finish_load("p5", 5);
    ld_valid = 1'b0;
    fetch("p5_a0",   32'd0,        48'hA1B2C3D4E500);
    fetch("p5_a3",   32'd3,        48'hD4E500000000);
    fetch("p5_wrap", 32'hFFFFFFFE, 48'h0);

    // Overfill: DEPTH+3 bytes with ld_valid held.
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      ld_valid = 1'b1;
      ld_data  = (i < DEPTH) ? pat(i) : 8'hEE;
      tick();
      if (i == DEPTH - 2) chk("full_ready_hi", 64'(ld_ready), 64'd1);
      if (i == DEPTH - 1) begin
        chk("full_ready_lo", 64'(ld_ready), 64'd0);
        chk("full_cnt_at",   64'(ld_count), 64'(DEPTH));
      end
    end
    ld_valid = 1'b0;
    chk("full_cnt_end", 64'(ld_count), 64'(DEPTH));
    chk("full_busy",    64'(rom_busy), 64'd1);
    finish_load("full", DEPTH);
    w = {pat(0), pat(1), pat(2), pat(3), pat(4), pat(5)};
    fetch("full_a0", 32'd0, w);
    w = {pat(DEPTH-2), pat(DEPTH-1), 32'h0};
    fetch("full_top", 32'(DEPTH - 2), w);
    fetch("full_past", 32'(DEPTH), 48'h0);

    // Restart mid-load with a byte and an end pulse in the same cycle.
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    send(8'h11); send(8'h22); send(8'h33);
    ld_start = 1'b1; ld_valid = 1'b1; ld_data = 8'h99; ld_end = 1'b1;
    tick();
    ld_start = 1'b0; ld_valid = 1'b0; ld_end = 1'b0;
    chk("rs_cnt",  64'(ld_count), 64'd0);
    chk("rs_busy", 64'(rom_busy), 64'd1);
    chk("rs_done", 64'(ld_done),  64'd0);
    send(8'h44);
    finish_load("rs", 1);
    fetch("rs_a0", 32'd0, 48'h440000000000);

    // Reset during a load.
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    chk("ar_cnt_pre", 64'(ld_count), 64'd4);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_cnt",   64'(ld_count), 64'd0);
    chk("ar_busy",  64'(rom_busy), 64'd0);
    chk("ar_ready", 64'(ld_ready), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("ar_done", 64'(ld_done), 64'd0);
    fetch("ar_a0", 32'd0, 48'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
